// File: rtl/butterfly_array_if.sv
// Beat stream between the coefficient RAM read port, the butterfly array and
// write-back. One instance carries the input beats and one carries the results.
// The result stream leaves mode and w at zero.
interface butterfly_array_if #(
   parameter int LANES = 4,
   parameter int W     = 12,
   parameter int TAG_W = 4
);
   logic                 valid;
   logic                 ready;
   logic [1:0]           mode;
   logic [LANES*W-1:0]   a;
   logic [LANES*W-1:0]   b;
   logic [LANES*W-1:0]   w;
   logic [TAG_W-1:0]     tag;

   modport master (output valid, mode, a, b, w, tag, input ready);
   modport slave  (input valid, mode, a, b, w, tag, output ready);
endinterface

// File: rtl/butterfly_array.sv
// butterfly_array: LANES modular butterflies mod Q, fully pipelined with a
// fixed latency of LAT cycles (LAT >= 2). Modes: CT, GS, ADDSUB, MUL.
// Mode and tag travel with each beat. A stall freezes every stage.
// Optional feature: define BFLY_INTT_HALVE_EN to halve both GS results mod Q,
// which folds the inverse-NTT 1/N scaling into the butterfly stages.
//
// Stage p0 holds the pre-added operands and the raw 2W-bit products.
// The first p1 stage holds the reduced and post-added results.
// The remaining p1 stages are a plain delay line, which gives retiming slack
// for the reduction logic.
module butterfly_array #(
   parameter int LANES = 4,
   parameter int W     = 12,
   parameter int Q     = 3329,
   parameter int LAT   = 4,
   parameter int TAG_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   butterfly_array_if.slave        in_s,
   butterfly_array_if.master       out_s,
   output logic                    busy
);

   typedef enum logic [1:0] {MODE_CT, MODE_GS, MODE_ADDSUB, MODE_MUL} mode_e;

`ifdef BFLY_INTT_HALVE_EN
   localparam bit HALVE = 1'b1;
`else
   localparam bit HALVE = 1'b0;
`endif

   localparam logic [W:0]     Q_W1 = (W+1)'(Q);
   localparam logic [2*W-1:0] Q_2W = (2*W)'(Q);

   // (x + y) mod Q for canonical x, y
   function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= Q_W1) s = s - Q_W1;
      return s[W-1:0];
   endfunction

   // (x - y) mod Q for canonical x, y
   function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] d;
      if (x >= y) d = {1'b0, x} - {1'b0, y};
      else        d = {1'b0, x} + Q_W1 - {1'b0, y};
      return d[W-1:0];
   endfunction

   // x/2 mod Q: an odd x becomes even once Q (odd) is added
   function automatic logic [W-1:0] halve(input logic [W-1:0] x);
      logic [W:0] h;
      h = x[0] ? ({1'b0, x} + Q_W1) : {1'b0, x};
      return h[W:1];
   endfunction

   // exact reduction of a 2W-bit product by the constant modulus
   function automatic logic [W-1:0] red_mod(input logic [2*W-1:0] p);
      logic [2*W-1:0] r;
      r = p % Q_2W;
      return r[W-1:0];
   endfunction

   logic                 stall;
   logic                 advance;

   logic [W-1:0]         keep_n [LANES];
   logic [2*W-1:0]       pa_n   [LANES];
   logic [2*W-1:0]       pb_n   [LANES];

   logic                 vld_p0;
   mode_e                mode_p0;
   logic [TAG_W-1:0]     tag_p0;
   logic [W-1:0]         keep_p0 [LANES];
   logic [2*W-1:0]       pa_p0   [LANES];
   logic [2*W-1:0]       pb_p0   [LANES];

   logic [LANES*W-1:0]   ra_n;
   logic [LANES*W-1:0]   rb_n;

   logic [LAT-2:0]       vld_p1;
   logic [TAG_W-1:0]     tag_p1 [LAT-1];
   logic [LANES*W-1:0]   ra_p1  [LAT-1];
   logic [LANES*W-1:0]   rb_p1  [LAT-1];

   assign stall        = out_s.valid & ~out_s.ready;
   assign advance      = ~stall;
   assign in_s.ready   = ~stall;

   assign out_s.valid  = vld_p1[LAT-2];
   assign out_s.a      = ra_p1[LAT-2];
   assign out_s.b      = rb_p1[LAT-2];
   assign out_s.tag    = tag_p1[LAT-2];
   assign out_s.mode   = '0;
   assign out_s.w      = '0;

   assign busy         = vld_p0 | (|vld_p1);

   // Pre-add/sub and operand select so that every mode needs two products per lane
   always_comb begin
      logic [W-1:0] a_v, b_v, w_v, sum_v, dif_v, xa_v, xb_v, yb_v;
      for (int k = 0; k < LANES; k++) begin
         a_v   = in_s.a[k*W +: W];
         b_v   = in_s.b[k*W +: W];
         w_v   = in_s.w[k*W +: W];
         sum_v = add_mod(a_v, b_v);
         dif_v = sub_mod(a_v, b_v);
         keep_n[k] = a_v;
         xa_v      = '0;
         xb_v      = b_v;
         yb_v      = w_v;
         case (mode_e'(in_s.mode))
            MODE_CT: begin
            end
            MODE_GS: begin
               keep_n[k] = HALVE ? halve(sum_v) : sum_v;
               xb_v      = HALVE ? halve(dif_v) : dif_v;
            end
            MODE_ADDSUB: begin
               keep_n[k] = sum_v;
               xb_v      = dif_v;
               yb_v      = W'(1);
            end
            default: begin
               keep_n[k] = '0;
               xa_v      = a_v;
            end
         endcase
         pa_n[k] = {{W{1'b0}}, xa_v} * {{W{1'b0}}, w_v};
         pb_n[k] = {{W{1'b0}}, xb_v} * {{W{1'b0}}, yb_v};
      end
   end

   // Stage p0: capture the beat with its pre-added operand and raw products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0  <= 1'b0;
         mode_p0 <= MODE_CT;
         tag_p0  <= '0;
         for (int k = 0; k < LANES; k++) begin
            keep_p0[k] <= '0;
            pa_p0[k]   <= '0;
            pb_p0[k]   <= '0;
         end
      end else if (advance) begin
         vld_p0  <= in_s.valid;
         mode_p0 <= mode_e'(in_s.mode);
         tag_p0  <= in_s.tag;
         for (int k = 0; k < LANES; k++) begin
            keep_p0[k] <= keep_n[k];
            pa_p0[k]   <= pa_n[k];
            pb_p0[k]   <= pb_n[k];
         end
      end
   end

   // Reduce the products and form the final per-lane results
   always_comb begin
      logic [W-1:0] t_v, u_v;
      ra_n = '0;
      rb_n = '0;
      for (int k = 0; k < LANES; k++) begin
         t_v = red_mod(pb_p0[k]);
         u_v = red_mod(pa_p0[k]);
         case (mode_p0)
            MODE_CT: begin
               ra_n[k*W +: W] = add_mod(keep_p0[k], t_v);
               rb_n[k*W +: W] = sub_mod(keep_p0[k], t_v);
            end
            MODE_MUL: begin
               ra_n[k*W +: W] = u_v;
               rb_n[k*W +: W] = t_v;
            end
            default: begin
               ra_n[k*W +: W] = keep_p0[k];
               rb_n[k*W +: W] = t_v;
            end
         endcase
      end
   end

   // Stages p1: result register followed by the delay line to the output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= '0;
         for (int i = 0; i < LAT-1; i++) begin
            tag_p1[i] <= '0;
            ra_p1[i]  <= '0;
            rb_p1[i]  <= '0;
         end
      end else if (advance) begin
         vld_p1[0] <= vld_p0;
         tag_p1[0] <= tag_p0;
         ra_p1[0]  <= ra_n;
         rb_p1[0]  <= rb_n;
         for (int i = 1; i < LAT-1; i++) begin
            vld_p1[i] <= vld_p1[i-1];
            tag_p1[i] <= tag_p1[i-1];
            ra_p1[i]  <= ra_p1[i-1];
            rb_p1[i]  <= rb_p1[i-1];
         end
      end
   end

endmodule

// File: tb/tb_butterfly_array.sv
// Bench for butterfly_array (LANES=4, W=12, Q=3329, LAT=4). Directed vectors
// per mode, a stalled mixed-mode stream, a mid-flight reset and a long random
// run checked against an independent mod-Q model.
module tb_butterfly_array;
   localparam int LANES = 4;
   localparam int W     = 12;
   localparam int Q     = 3329;
   localparam int LAT   = 4;
   localparam int TAG_W = 4;
   localparam logic [1:0] M_CT = 2'd0, M_GS = 2'd1, M_AS = 2'd2, M_MUL = 2'd3;

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [LANES*W-1:0] a;
      logic [LANES*W-1:0] b;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   n_tests = 0;
   int   n_fail  = 0;

   butterfly_array_if #(.LANES(LANES), .W(W), .TAG_W(TAG_W)) in_s ();
   butterfly_array_if #(.LANES(LANES), .W(W), .TAG_W(TAG_W)) out_s ();

   butterfly_array #(.LANES(LANES), .W(W), .Q(Q), .LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in_s  (in_s),
      .out_s (out_s),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // Golden per-lane model, plain integer arithmetic
   function automatic void model(input logic [1:0] m, input logic [LANES*W-1:0] a,
                                 input logic [LANES*W-1:0] b, input logic [LANES*W-1:0] w,
                                 output logic [LANES*W-1:0] ra, output logic [LANES*W-1:0] rb);
      int x, y, z, s, d, t;
      ra = '0;
      rb = '0;
      for (int k = 0; k < LANES; k++) begin
         x = int'(a[k*W +: W]);
         y = int'(b[k*W +: W]);
         z = int'(w[k*W +: W]);
         s = (x + y) % Q;
         d = (x - y + Q) % Q;
         case (m)
            M_CT: begin
               t = (y * z) % Q;
               ra[k*W +: W] = W'((x + t) % Q);
               rb[k*W +: W] = W'((x - t + Q) % Q);
            end
            M_GS: begin
`ifdef BFLY_INTT_HALVE_EN
               s = (s * ((Q + 1) / 2)) % Q;
               d = (d * ((Q + 1) / 2)) % Q;
`endif
               ra[k*W +: W] = W'(s);
               rb[k*W +: W] = W'((d * z) % Q);
            end
            M_AS: begin
               ra[k*W +: W] = W'(s);
               rb[k*W +: W] = W'(d);
            end
            default: begin
               ra[k*W +: W] = W'((x * z) % Q);
               rb[k*W +: W] = W'((y * z) % Q);
            end
         endcase
      end
   endfunction

   task automatic put_beat(input logic [1:0] m, input logic [LANES*W-1:0] a,
                           input logic [LANES*W-1:0] b, input logic [LANES*W-1:0] w,
                           input logic [TAG_W-1:0] t);
      in_s.mode  = m;
      in_s.a     = a;
      in_s.b     = b;
      in_s.w     = w;
      in_s.tag   = t;
      in_s.valid = 1'b1;
   endtask

   // Holds the current beat until it is taken; returns 1 just after the accepting edge
   task automatic accept(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_s.ready) ok = 1'b1;
         @(posedge clk);
         #1;
         if (ok) break;
      end
   endtask

   // Counts cycles after the accepting edge until out_valid is seen
   task automatic wait_out(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (out_s.valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_single(input logic [1:0] m, input logic [LANES*W-1:0] a,
                             input logic [LANES*W-1:0] b, input logic [LANES*W-1:0] w,
                             input logic [TAG_W-1:0] t,
                             output logic [LANES*W-1:0] ra, output logic [LANES*W-1:0] rb,
                             output logic [TAG_W-1:0] rt, output int cyc, output bit ok);
      bit acc;
      @(posedge clk);
      #1;
      put_beat(m, a, b, w, t);
      accept(acc);
      in_s.valid = 1'b0;
      cyc = 0;
      ok  = 1'b0;
      if (acc) wait_out(cyc, ok);
      ra = out_s.a;
      rb = out_s.b;
      rt = out_s.tag;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_tests++; if (out_s.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_s.valid); end
      n_tests++; if (out_s.a !== '0 || out_s.b !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h/%h want=0", out_s.a, out_s.b); end
      n_tests++; if (out_s.tag !== '0) begin n_fail++; $display("FAIL reset_out_tag got=%h want=0", out_s.tag); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++; if (in_s.ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_s.ready); end
   endtask

   task automatic test_ct();
      logic [LANES*W-1:0] ra, rb;
      logic [TAG_W-1:0] rt;
      int cyc;
      bit ok;
      run_single(M_CT, {4{12'd1}}, {4{12'd2}}, {4{12'd17}}, 4'h3, ra, rb, rt, cyc, ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ct_out_seen got=%b want=1", ok); end
      n_tests++; if (cyc !== LAT) begin n_fail++; $display("FAIL ct_latency got=%0d want=%0d", cyc, LAT); end
      n_tests++; if (ra !== {4{12'd35}}) begin n_fail++; $display("FAIL ct_out_a got=%h want=%h", ra, {4{12'd35}}); end
      n_tests++; if (rb !== {4{12'd3296}}) begin n_fail++; $display("FAIL ct_out_b got=%h want=%h", rb, {4{12'd3296}}); end
      n_tests++; if (rt !== 4'h3) begin n_fail++; $display("FAIL ct_tag got=%h want=3", rt); end
   endtask

   task automatic test_gs();
      logic [LANES*W-1:0] ra, rb, ea, eb;
      logic [TAG_W-1:0] rt;
      int cyc;
      bit ok;
`ifdef BFLY_INTT_HALVE_EN
      ea = {4{12'd1672}};
      eb = {4{12'd1622}};
`else
      ea = {4{12'd15}};
      eb = {4{12'd3244}};
`endif
      run_single(M_GS, {4{12'd5}}, {4{12'd10}}, {4{12'd17}}, 4'h9, ra, rb, rt, cyc, ok);
      n_tests++; if (cyc !== LAT || ok !== 1'b1) begin n_fail++; $display("FAIL gs_latency got=%0d want=%0d", cyc, LAT); end
      n_tests++; if (ra !== ea) begin n_fail++; $display("FAIL gs_out_a got=%h want=%h", ra, ea); end
      n_tests++; if (rb !== eb) begin n_fail++; $display("FAIL gs_out_b got=%h want=%h", rb, eb); end
      n_tests++; if (rt !== 4'h9) begin n_fail++; $display("FAIL gs_tag got=%h want=9", rt); end
   endtask

   task automatic test_addsub_mul();
      logic [LANES*W-1:0] ra, rb;
      logic [TAG_W-1:0] rt;
      int cyc;
      bit ok;
      run_single(M_AS, {4{12'd3328}}, {4{12'd1}}, {4{12'd77}}, 4'hA, ra, rb, rt, cyc, ok);
      n_tests++; if (ra !== {4{12'd0}} || ok !== 1'b1) begin n_fail++; $display("FAIL addsub_out_a got=%h want=0", ra); end
      n_tests++; if (rb !== {4{12'd3327}}) begin n_fail++; $display("FAIL addsub_out_b got=%h want=%h", rb, {4{12'd3327}}); end
      run_single(M_MUL, {4{12'd3328}}, {4{12'd2}}, {4{12'd3328}}, 4'hB, ra, rb, rt, cyc, ok);
      n_tests++; if (ra !== {4{12'd1}} || ok !== 1'b1) begin n_fail++; $display("FAIL mul_out_a got=%h want=%h", ra, {4{12'd1}}); end
      n_tests++; if (rb !== {4{12'd3327}}) begin n_fail++; $display("FAIL mul_out_b got=%h want=%h", rb, {4{12'd3327}}); end
      n_tests++; if (rt !== 4'hB) begin n_fail++; $display("FAIL mul_tag got=%h want=b", rt); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]         m_l [10];
      logic [LANES*W-1:0] a_l [10], b_l [10], w_l [10], ea [10], eb [10];
      logic [2*LANES*W+TAG_W-1:0] prev;
      bit prev_stall = 1'b0;
      bit drv_ok = 1'b1;
      int got = 0;
      for (int i = 0; i < 10; i++) begin
         m_l[i] = (i % 2 == 1) ? M_AS : M_CT;
         a_l[i] = {12'(i*300 + 1), 12'(3328 - i), 12'(i*17), 12'(2000 + i)};
         b_l[i] = {12'(i*111), 12'(i + 1), 12'd3328, 12'(5*i)};
         w_l[i] = {12'(17 + i), 12'd1729, 12'(3328 - 3*i), 12'(i)};
         model(m_l[i], a_l[i], b_l[i], w_l[i], ea[i], eb[i]);
      end
      prev = '0;
      fork
         begin
            bit acc;
            @(posedge clk);
            #1;
            for (int i = 0; i < 10; i++) begin
               put_beat(m_l[i], a_l[i], b_l[i], w_l[i], 4'(i));
               accept(acc);
               if (!acc) begin
                  drv_ok = 1'b0;
                  break;
               end
            end
            in_s.valid = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            out_s.ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_s.ready = 1'b1;
         end
         begin
            for (int c = 0; c < 200 && got < 10; c++) begin
               @(negedge clk);
               if (out_s.valid && !out_s.ready) begin
                  n_tests++;
                  if (in_s.ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b want=0", in_s.ready); end
                  if (prev_stall) begin
                     n_tests++;
                     if ({out_s.tag, out_s.a, out_s.b} !== prev) begin
                        n_fail++; $display("FAIL stall_stable got=%h want=%h", {out_s.tag, out_s.a, out_s.b}, prev);
                     end
                  end
                  prev       = {out_s.tag, out_s.a, out_s.b};
                  prev_stall = 1'b1;
               end else begin
                  prev_stall = 1'b0;
               end
               if (out_s.valid && out_s.ready) begin
                  n_tests++;
                  if (out_s.tag !== 4'(got) || out_s.a !== ea[got] || out_s.b !== eb[got]) begin
                     n_fail++;
                     $display("FAIL stream_beat%0d got tag=%h a=%h b=%h want tag=%h a=%h b=%h",
                              got, out_s.tag, out_s.a, out_s.b, 4'(got), ea[got], eb[got]);
                  end
                  got++;
               end
            end
         end
      join
      n_tests++; if (got !== 10 || drv_ok !== 1'b1) begin n_fail++; $display("FAIL stream_count got=%0d want=10", got); end
      repeat (LAT + 1) @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_drain_busy got=%b want=0", busy); end
   endtask

   task automatic test_reset_mid();
      logic [LANES*W-1:0] ra, rb;
      logic [TAG_W-1:0] rt;
      int cyc;
      int stale = 0;
      bit ok;
      bit acc;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         put_beat(M_CT, {4{12'(i + 1)}}, {4{12'd2}}, {4{12'd17}}, 4'(i + 12));
         accept(acc);
      end
      in_s.valid = 1'b0;
      @(posedge clk);
      #1;
      n_tests++; if (out_s.valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_before got valid=%b busy=%b want 1/1", out_s.valid, busy); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (out_s.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b want=0", out_s.valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++; if (in_s.ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b want=1", in_s.ready); end
      for (int i = 0; i < 2*LAT; i++) begin
         if (out_s.valid || busy) stale++;
         @(negedge clk);
      end
      n_tests++; if (stale !== 0) begin n_fail++; $display("FAIL rstmid_stale got=%0d cycles want=0", stale); end
      run_single(M_CT, {4{12'd1}}, {4{12'd2}}, {4{12'd17}}, 4'h7, ra, rb, rt, cyc, ok);
      n_tests++; if (cyc !== LAT || ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_latency got=%0d want=%0d", cyc, LAT); end
      n_tests++; if (ra !== {4{12'd35}} || rb !== {4{12'd3296}} || rt !== 4'h7) begin
         n_fail++; $display("FAIL rstmid_new_data got=%h/%h/%h want=%h/%h/7", ra, rb, rt, {4{12'd35}}, {4{12'd3296}});
      end
   endtask

   task automatic test_random();
      localparam int NB = 10000;
      exp_t q[$];
      exp_t e;
      bit mon_done = 1'b0;
      bit drv_ok   = 1'b1;
      int got      = 0;
      fork
         begin
            logic [1:0] m;
            logic [LANES*W-1:0] a, b, w, ra, rb;
            bit acc;
            @(posedge clk);
            #1;
            for (int i = 0; i < NB; i++) begin
               m = 2'($urandom_range(0, 3));
               for (int k = 0; k < LANES; k++) begin
                  a[k*W +: W] = W'($urandom_range(0, Q - 1));
                  b[k*W +: W] = W'($urandom_range(0, Q - 1));
                  w[k*W +: W] = W'($urandom_range(0, Q - 1));
               end
               if ($urandom_range(0, 4) == 0) begin
                  in_s.valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
               put_beat(m, a, b, w, 4'(i));
               acc = 1'b0;
               for (int t = 0; t < 1000; t++) begin
                  @(negedge clk);
                  if (in_s.ready) begin
                     model(m, a, b, w, ra, rb);
                     q.push_back('{tag: 4'(i), a: ra, b: rb});
                     acc = 1'b1;
                  end
                  @(posedge clk);
                  #1;
                  if (acc) break;
               end
               if (!acc) begin
                  drv_ok = 1'b0;
                  break;
               end
            end
            in_s.valid = 1'b0;
         end
         begin
            while (!mon_done) begin
               @(posedge clk);
               #1;
               out_s.ready = ($urandom_range(0, 3) != 0);
            end
            out_s.ready = 1'b1;
         end
         begin
            for (int c = 0; c < 60000 && got < NB; c++) begin
               @(negedge clk);
               if (out_s.valid && out_s.ready) begin
                  n_tests++;
                  if (q.size() == 0) begin
                     n_fail++; $display("FAIL rand_unexpected got tag=%h want no beat", out_s.tag);
                  end else begin
                     e = q.pop_front();
                     if (out_s.tag !== e.tag || out_s.a !== e.a || out_s.b !== e.b) begin
                        n_fail++;
                        $display("FAIL rand_beat%0d got tag=%h a=%h b=%h want tag=%h a=%h b=%h",
                                 got, out_s.tag, out_s.a, out_s.b, e.tag, e.a, e.b);
                     end
                  end
                  got++;
               end
            end
            mon_done = 1'b1;
         end
      join
      n_tests++; if (got !== NB || drv_ok !== 1'b1) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", got, NB); end
   endtask

   initial begin
      in_s.valid  = 1'b0;
      in_s.mode   = '0;
      in_s.a      = '0;
      in_s.b      = '0;
      in_s.w      = '0;
      in_s.tag    = '0;
      out_s.ready = 1'b1;
      test_reset();
      test_ct();
      test_gs();
      test_addsub_mul();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
